// File: rtl/seqpu_bus_pkg.sv
// Shared types and constants for the external SRAM bus arbiter.
//   arb_state_e : arbiter FSM states
//   STROBE_*    : active-low strobe levels for mem_wren_n / mem_oen_n
//   MASTER_*    : encoding of the owner / last-owner tag
//   access_t    : one bus access (address, write data, direction)
package seqpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN0   = 2'd1,
        OWN1   = 2'd2,
        SWITCH = 2'd3
    } arb_state_e;

    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

    localparam int BUS_AW = 16;
    localparam int BUS_DW = 16;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
        logic              we;
    } access_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin selector.
//   req[1:0] : request from M1 (bit 1) and M0 (bit 0)
//   last     : master that owned the bus most recently
//   winner   : selected master; on a tie the master that was not last wins
module arb_rr_pick
    import seqpu_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = MASTER_M0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = MASTER_M1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one external SRAM port between M0 (CPU) and M1 (DMA).
//   clk, rst                  : clock, asynchronous active-high reset
//   mX_req/we/addr/wdata      : master request channel
//   mX_gnt                    : access accepted when mX_req && mX_gnt
//   mX_rdata/mX_rvalid        : read return, two edges after acceptance
//   mem_address/data_out      : registered SRAM address / write data
//   mem_data_in               : SRAM read data
//   mem_wren_n/mem_oen_n      : registered active-low strobes
//
// state  | meaning
// IDLE   | no owner, next requester takes the bus without a dead cycle
// OWN0   | M0 owns the bus, one access per granted cycle
// OWN1   | M1 owns the bus, one access per granted cycle
// SWITCH | dead cycle between owners, no grant, strobes idle
module mem_bus_arbiter
    import seqpu_bus_pkg::*;
#(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data_out,
    input  logic [DW-1:0] mem_data_in,
    output logic          mem_wren_n,
    output logic          mem_oen_n
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_data_out_q, mem_data_out_d;
    logic          mem_wren_n_q, mem_wren_n_d;
    logic          mem_oen_n_q, mem_oen_n_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_tag_q, rd_tag_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;

    logic    cap0, cap1, acc0, acc1, acc_valid, winner;
    access_t acc_sel;

    // The cap only bites while the other master is actually waiting.
    assign cap0 = (hold_q == HOLD_MAX) && m1_req;
    assign cap1 = (hold_q == HOLD_MAX) && m0_req;

    assign m0_gnt = (state_q == OWN0) && !cap0;
    assign m1_gnt = (state_q == OWN1) && !cap1;

    assign acc0      = m0_req && m0_gnt;
    assign acc1      = m1_req && m1_gnt;
    assign acc_valid = acc0 || acc1;

    arb_rr_pick u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .winner (winner)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = (winner == MASTER_M1) ? OWN1 : OWN0;
                end
            end
            OWN0: begin
                if (!m0_req || cap0) begin
                    state_d = m1_req ? SWITCH : IDLE;
                    last_d  = MASTER_M0;
                    hold_d  = '0;
                end else if (acc0 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            OWN1: begin
                if (!m1_req || cap1) begin
                    state_d = m0_req ? SWITCH : IDLE;
                    last_d  = MASTER_M1;
                    hold_d  = '0;
                end else if (acc1 && hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            SWITCH: begin
                // Target was fixed when the previous owner left; last names it.
                state_d = (last_q == MASTER_M0) ? OWN1 : OWN0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_sel.addr  = acc1 ? BUS_AW'(m1_addr)  : BUS_AW'(m0_addr);
        acc_sel.wdata = acc1 ? BUS_DW'(m1_wdata) : BUS_DW'(m0_wdata);
        acc_sel.we    = acc1 ? m1_we : m0_we;

        mem_address_d  = mem_address_q;
        mem_data_out_d = mem_data_out_q;
        mem_wren_n_d   = STROBE_IDLE;
        mem_oen_n_d    = STROBE_IDLE;
        rd_pend_d      = 1'b0;
        rd_tag_d       = rd_tag_q;
        if (acc_valid) begin
            mem_address_d  = AW'(acc_sel.addr);
            mem_data_out_d = DW'(acc_sel.wdata);
            if (acc_sel.we) begin
                mem_wren_n_d = STROBE_ACTIVE;
            end else begin
                mem_oen_n_d = STROBE_ACTIVE;
                rd_pend_d   = 1'b1;
                rd_tag_d    = acc1 ? MASTER_M1 : MASTER_M0;
            end
        end

        // Read data lands at the end of the mem cycle and goes to the issuer.
        m0_rvalid_d = rd_pend_q && (rd_tag_q == MASTER_M0);
        m1_rvalid_d = rd_pend_q && (rd_tag_q == MASTER_M1);
        m0_rdata_d  = m0_rvalid_d ? mem_data_in : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? mem_data_in : m1_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= MASTER_M1;
            hold_q         <= '0;
            mem_address_q  <= '0;
            mem_data_out_q <= '0;
            mem_wren_n_q   <= STROBE_IDLE;
            mem_oen_n_q    <= STROBE_IDLE;
            rd_pend_q      <= 1'b0;
            rd_tag_q       <= MASTER_M0;
            m0_rvalid_q    <= 1'b0;
            m1_rvalid_q    <= 1'b0;
            m0_rdata_q     <= '0;
            m1_rdata_q     <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            hold_q         <= hold_d;
            mem_address_q  <= mem_address_d;
            mem_data_out_q <= mem_data_out_d;
            mem_wren_n_q   <= mem_wren_n_d;
            mem_oen_n_q    <= mem_oen_n_d;
            rd_pend_q      <= rd_pend_d;
            rd_tag_q       <= rd_tag_d;
            m0_rvalid_q    <= m0_rvalid_d;
            m1_rvalid_q    <= m1_rvalid_d;
            m0_rdata_q     <= m0_rdata_d;
            m1_rdata_q     <= m1_rdata_d;
        end
    end

    assign mem_address  = mem_address_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_wren_n   = mem_wren_n_q;
    assign mem_oen_n    = mem_oen_n_q;
    assign m0_rvalid    = m0_rvalid_q;
    assign m1_rvalid    = m1_rvalid_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic [15:0] mem_address, mem_data_out, mem_data_in;
    logic        mem_wren_n, mem_oen_n;

    int checks = 0;
    int errors = 0;
    int rd_acc = 0;
    int rv_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(16), .DW(16), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_gnt       (m0_gnt),
        .m0_rdata     (m0_rdata),
        .m0_rvalid    (m0_rvalid),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_gnt       (m1_gnt),
        .m1_rdata     (m1_rdata),
        .m1_rvalid    (m1_rvalid),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_wren_n   (mem_wren_n),
        .mem_oen_n    (mem_oen_n)
    );

    typedef struct {
        logic        m0_req, m0_we;
        logic [15:0] m0_addr, m0_wdata;
        logic        m1_req, m1_we;
        logic [15:0] m1_addr, m1_wdata;
        logic [15:0] din;
        logic        g0, g1, wren_n, oen_n;
        logic [15:0] addr, dout;
        logic        rv0, rv1;
        logic [15:0] rd0, rd1;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus-level invariants, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!mem_wren_n && !mem_oen_n) begin
                errors++;
                $display("FAIL strobe_overlap: got wren_n=0 oen_n=0 expected not both low");
            end
            checks++;
            if (m0_gnt && m1_gnt) begin
                errors++;
                $display("FAIL dual_grant: got both gnt=1 expected at most one");
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (m0_req && m0_gnt && !m0_we) rd_acc++;
            if (m1_req && m1_gnt && !m1_we) rd_acc++;
            if (m0_rvalid) rv_cnt++;
            if (m1_rvalid) rv_cnt++;
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        mem_data_in = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            m0 req we addr   wdata  m1 req we addr   wdata  din      g0 g1 wr oe addr   dout   rv0 rv1 rd0    rd1
        vecs[0]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[1]  = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[2]  = '{1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[3]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hBEEF, 1,0,1,0, 16'h0010,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[4]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 1,0,16'hBEEF,16'h0000};
        vecs[5]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0100,16'h00A0, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[6]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0100,16'h00A0, 16'h0000, 0,1,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[7]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0101,16'h00A1, 16'h0000, 0,1,0,1, 16'h0100,16'h00A0, 0,0,16'h0000,16'h0000};
        vecs[8]  = '{0,0,16'h0000,16'h0000, 1,1,16'h0102,16'h00A2, 16'h0000, 0,1,0,1, 16'h0101,16'h00A1, 0,0,16'h0000,16'h0000};
        vecs[9]  = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,1,0,1, 16'h0102,16'h00A2, 0,0,16'h0000,16'h0000};
        vecs[10] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[11] = '{1,0,16'h0020,16'h0000, 1,1,16'h0200,16'h5555, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[12] = '{1,0,16'h0020,16'h0000, 1,1,16'h0200,16'h5555, 16'h0000, 1,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[13] = '{1,0,16'h0021,16'h0000, 1,1,16'h0200,16'h5555, 16'h1111, 1,0,1,0, 16'h0020,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[14] = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'h5555, 16'h2222, 1,0,1,0, 16'h0021,16'h0000, 1,0,16'h1111,16'h0000};
        vecs[15] = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'h5555, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 1,0,16'h2222,16'h0000};
        vecs[16] = '{0,0,16'h0000,16'h0000, 1,1,16'h0200,16'h5555, 16'h0000, 0,1,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[17] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,1,0,1, 16'h0200,16'h5555, 0,0,16'h0000,16'h0000};
        vecs[18] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[19] = '{1,0,16'h0030,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[20] = '{1,0,16'h0030,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 1,0,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[21] = '{1,0,16'h0031,16'h0000, 1,0,16'h0300,16'h0000, 16'hD000, 1,0,1,0, 16'h0030,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[22] = '{1,0,16'h0032,16'h0000, 1,0,16'h0300,16'h0000, 16'hD001, 1,0,1,0, 16'h0031,16'h0000, 1,0,16'hD000,16'h0000};
        vecs[23] = '{1,0,16'h0033,16'h0000, 1,0,16'h0300,16'h0000, 16'hD002, 1,0,1,0, 16'h0032,16'h0000, 1,0,16'hD001,16'h0000};
        vecs[24] = '{1,0,16'h0034,16'h0000, 1,0,16'h0300,16'h0000, 16'hD003, 0,0,1,0, 16'h0033,16'h0000, 1,0,16'hD002,16'h0000};
        vecs[25] = '{1,0,16'h0034,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 1,0,16'hD003,16'h0000};
        vecs[26] = '{1,0,16'h0034,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000, 0,1,1,1, 16'h0000,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[27] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hE000, 0,1,1,0, 16'h0300,16'h0000, 0,0,16'h0000,16'h0000};
        vecs[28] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,1,1, 16'h0000,16'h0000, 0,1,16'h0000,16'hE000};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_gnt", 16'(m0_gnt), 16'd0);
        chk("rst_m1_gnt", 16'(m1_gnt), 16'd0);
        chk("rst_m0_rvalid", 16'(m0_rvalid), 16'd0);
        chk("rst_m1_rvalid", 16'(m1_rvalid), 16'd0);
        chk("rst_m0_rdata", m0_rdata, 16'h0000);
        chk("rst_m1_rdata", m1_rdata, 16'h0000);
        chk("rst_wren_n", 16'(mem_wren_n), 16'd1);
        chk("rst_oen_n", 16'(mem_oen_n), 16'd1);
        chk("rst_address", mem_address, 16'h0000);
        chk("rst_data_out", mem_data_out, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            m0_req = vecs[i].m0_req; m0_we = vecs[i].m0_we;
            m0_addr = vecs[i].m0_addr; m0_wdata = vecs[i].m0_wdata;
            m1_req = vecs[i].m1_req; m1_we = vecs[i].m1_we;
            m1_addr = vecs[i].m1_addr; m1_wdata = vecs[i].m1_wdata;
            mem_data_in = vecs[i].din;
            @(negedge clk);
            chk($sformatf("v%0d_m0_gnt", i), 16'(m0_gnt), 16'(vecs[i].g0));
            chk($sformatf("v%0d_m1_gnt", i), 16'(m1_gnt), 16'(vecs[i].g1));
            chk($sformatf("v%0d_wren_n", i), 16'(mem_wren_n), 16'(vecs[i].wren_n));
            chk($sformatf("v%0d_oen_n", i), 16'(mem_oen_n), 16'(vecs[i].oen_n));
            if (!vecs[i].wren_n || !vecs[i].oen_n)
                chk($sformatf("v%0d_address", i), mem_address, vecs[i].addr);
            if (!vecs[i].wren_n)
                chk($sformatf("v%0d_data_out", i), mem_data_out, vecs[i].dout);
            chk($sformatf("v%0d_m0_rvalid", i), 16'(m0_rvalid), 16'(vecs[i].rv0));
            chk($sformatf("v%0d_m1_rvalid", i), 16'(m1_rvalid), 16'(vecs[i].rv1));
            if (vecs[i].rv0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rd0);
            if (vecs[i].rv1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].rd1);
            next_cycle();
        end
        chk("read_vs_rvalid_count", 16'(rv_cnt), 16'(rd_acc));

        // Asynchronous reset in the middle of a write cycle.
        m1_req = 1; m1_we = 1; m1_addr = 16'h0400; m1_wdata = 16'h1234;
        next_cycle();
        next_cycle();
        m1_req = 0;
        chk("pre_arst_wren_n", 16'(mem_wren_n), 16'd0);
        chk("pre_arst_address", mem_address, 16'h0400);
        #2 rst = 1'b1;
        #1;
        chk("arst_wren_n", 16'(mem_wren_n), 16'd1);
        chk("arst_oen_n", 16'(mem_oen_n), 16'd1);
        chk("arst_address", mem_address, 16'h0000);
        chk("arst_data_out", mem_data_out, 16'h0000);
        chk("arst_m1_gnt", 16'(m1_gnt), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        next_cycle();

        // Read accepted, then a short reset pulse before its data returns.
        m0_req = 1; m0_we = 0; m0_addr = 16'h0050;
        next_cycle();
        next_cycle();
        m0_req = 0;
        mem_data_in = 16'h7777;
        chk("rdrst_oen_n_before", 16'(mem_oen_n), 16'd0);
        rst = 1'b1;
        #1;
        chk("rdrst_oen_n_async", 16'(mem_oen_n), 16'd1);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rdrst_m0_rvalid_%0d", k), 16'(m0_rvalid), 16'd0);
            chk($sformatf("rdrst_m1_rvalid_%0d", k), 16'(m1_rvalid), 16'd0);
        end
        next_cycle();

        // First tie after reset goes to M0.
        m0_req = 1; m0_we = 0; m0_addr = 16'h0060;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0600;
        @(negedge clk);
        chk("tie_idle_m0_gnt", 16'(m0_gnt), 16'd0);
        chk("tie_idle_m1_gnt", 16'(m1_gnt), 16'd0);
        next_cycle();
        @(negedge clk);
        chk("tie_m0_gnt", 16'(m0_gnt), 16'd1);
        chk("tie_m1_gnt", 16'(m1_gnt), 16'd0);
        next_cycle();
        idle_inputs();
        repeat (4) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
